// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over a window of
// 1/10/100/1000 gate units and exposes the latched result through a
// byte-wide snapshot shadow.
module freq_meter #(
  parameter int unsigned GATE_UNIT = 250000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic       sys_clk_25m,
  input  logic       sys_rst,
  input  logic       sig_in,
  input  logic       meas_en,
  input  logic [1:0] gate_sel,
  input  logic       rd_snap,
  input  logic [2:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       meas_busy,
  output logic       meas_done
);

  localparam int unsigned    UnitW   = (GATE_UNIT > 1) ? $clog2(GATE_UNIT) : 1;
  localparam logic [UnitW-1:0] UnitMax = UnitW'(GATE_UNIT - 1);

  typedef enum logic [1:0] {StIdle, StGate, StLatch} state_t;

  state_t           state_q, state_d;
  logic             sig_meta_q, sig_sync_q, sig_prev_q, sig_edge;
  logic [UnitW-1:0] unit_cnt_q;
  logic [9:0]       dec_cnt_q, dec_max;
  logic [1:0]       gate_sel_q;
  logic [CNT_W-1:0] edge_cnt_q, result_q, shadow_res_q;
  logic             edge_ovf_q, ovf_q, valid_q;
  logic [7:0]       shadow_st_q;
  logic             gate_start, gate_last;
  logic [31:0]      shadow_ext;

  // Two-flop synchroniser plus one history flop for rising-edge detect.
  always_ff @(posedge sys_clk_25m) begin
    if (sys_rst) begin
      sig_meta_q <= 1'b0;
      sig_sync_q <= 1'b0;
      sig_prev_q <= 1'b0;
    end else begin
      sig_meta_q <= sig_in;
      sig_sync_q <= sig_meta_q;
      sig_prev_q <= sig_sync_q;
    end
  end

  assign sig_edge = sig_sync_q & ~sig_prev_q;

  // Last unit index of the gate, from the gate length captured at gate start.
  always_comb begin
    dec_max = 10'd999;
    case (gate_sel_q)
      2'd0:    dec_max = 10'd0;
      2'd1:    dec_max = 10'd9;
      2'd2:    dec_max = 10'd99;
      default: dec_max = 10'd999;
    endcase
  end

  assign gate_last = (unit_cnt_q == UnitMax) && (dec_cnt_q == dec_max);

  // State register.
  always_ff @(posedge sys_clk_25m) begin
    if (sys_rst) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state and status outputs; dropping meas_en aborts an open gate.
  always_comb begin
    state_d    = state_q;
    meas_busy  = 1'b0;
    meas_done  = 1'b0;
    gate_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (meas_en) begin
          state_d    = StGate;
          gate_start = 1'b1;
        end
      end
      StGate: begin
        meas_busy = 1'b1;
        if (!meas_en)       state_d = StIdle;
        else if (gate_last) state_d = StLatch;
      end
      StLatch: begin
        meas_done = 1'b1;
        if (meas_en) begin
          state_d    = StGate;
          gate_start = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gate timing and saturating edge counter; only GATE cycles count edges.
  always_ff @(posedge sys_clk_25m) begin
    if (sys_rst) begin
      unit_cnt_q <= '0;
      dec_cnt_q  <= '0;
      edge_cnt_q <= '0;
      edge_ovf_q <= 1'b0;
      gate_sel_q <= 2'd0;
    end else if (gate_start) begin
      unit_cnt_q <= '0;
      dec_cnt_q  <= '0;
      edge_cnt_q <= '0;
      edge_ovf_q <= 1'b0;
      gate_sel_q <= gate_sel;
    end else if (state_q == StGate) begin
      if (unit_cnt_q == UnitMax) begin
        unit_cnt_q <= '0;
        dec_cnt_q  <= dec_cnt_q + 1'b1;
      end else begin
        unit_cnt_q <= unit_cnt_q + 1'b1;
      end
      if (sig_edge) begin
        if (&edge_cnt_q) edge_ovf_q <= 1'b1;
        else             edge_cnt_q <= edge_cnt_q + 1'b1;
      end
    end
  end

  // Result latch, read-and-clear valid (latch wins), and snapshot shadow.
  always_ff @(posedge sys_clk_25m) begin
    if (sys_rst) begin
      result_q     <= '0;
      ovf_q        <= 1'b0;
      valid_q      <= 1'b0;
      shadow_res_q <= '0;
      shadow_st_q  <= 8'h00;
    end else begin
      if (state_q == StLatch) begin
        result_q <= edge_cnt_q;
        ovf_q    <= edge_ovf_q;
      end
      if (state_q == StLatch) valid_q <= 1'b1;
      else if (rd_snap)       valid_q <= 1'b0;
      // Shadow takes pre-edge values, so a snap during LATCH sees the old result.
      if (rd_snap) begin
        shadow_res_q <= result_q;
        shadow_st_q  <= {4'b0000, meas_busy, ovf_q, valid_q, 1'b1};
      end
    end
  end

  assign shadow_ext = 32'(shadow_res_q);

  // Byte mux over the shadow only.
  always_comb begin
    rd_data = 8'h00;
    case (rd_sel)
      3'd0:    rd_data = shadow_ext[7:0];
      3'd1:    rd_data = shadow_ext[15:8];
      3'd2:    rd_data = shadow_ext[23:16];
      3'd3:    rd_data = shadow_ext[31:24];
      3'd4:    rd_data = shadow_st_q;
      default: rd_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed sequence with randomized input waveforms,
// checked against an edge-list model of gate windows and snapshot rules.
module tb_freq_meter;

  localparam int unsigned Unit = 100;

  logic       clk = 1'b0;
  logic       sys_rst, sig_in, meas_en, rd_snap;
  logic [1:0] gate_sel;
  logic [2:0] rd_sel;
  logic [7:0] rd_data, rd_data_s;
  logic       busy, done, busy_s, done_s;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rises[$];
  logic sig_last = 1'b0;
  int   per = 10;
  int   hi = 5;
  bit   sig_run = 1'b0;
  int   m_res = 0;
  bit   m_valid = 1'b0;

  always #5 clk = ~clk;

  freq_meter #(.GATE_UNIT(Unit), .CNT_W(32)) dut (
    .sys_clk_25m(clk), .sys_rst(sys_rst), .sig_in(sig_in), .meas_en(meas_en),
    .gate_sel(gate_sel), .rd_snap(rd_snap), .rd_sel(rd_sel), .rd_data(rd_data),
    .meas_busy(busy), .meas_done(done)
  );

  // Narrow counter instance in lockstep, to reach saturation quickly.
  freq_meter #(.GATE_UNIT(Unit), .CNT_W(4)) dut_sat (
    .sys_clk_25m(clk), .sys_rst(sys_rst), .sig_in(sig_in), .meas_en(meas_en),
    .gate_sel(gate_sel), .rd_snap(rd_snap), .rd_sel(rd_sel), .rd_data(rd_data_s),
    .meas_busy(busy_s), .meas_done(done_s)
  );

  // Clock index and the list of clock indices at which sig_in is first seen high.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sys_rst) begin
      sig_last <= 1'b0;
    end else begin
      if (sig_in && !sig_last) rises.push_back(cyc + 1);
      sig_last <= sig_in;
    end
  end

  // Square wave of period per with hi cycles high, changing on falling edges.
  initial begin : sig_gen
    int ph;
    ph = $urandom_range(0, 9);
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (sig_run) begin
        ph = ph + 1;
        if (ph >= per) ph = 0;
        sig_in = (ph < hi);
      end else begin
        sig_in = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edges seen at clock a-1..b-1 reach the counter while the gate covers a..b.
  function automatic int count_rises(input int a, input int b);
    int n = 0;
    foreach (rises[i]) if (rises[i] + 1 >= a && rises[i] + 1 <= b) n++;
    return n;
  endfunction

  function automatic logic [31:0] sat4(input int n);
    return (n > 15) ? 32'd15 : 32'(n);
  endfunction

  task automatic wait_done(input string tag, input int exp_cyc);
    int got = -1;
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = cyc;
        break;
      end
    end
    check(tag, 32'(got), 32'(exp_cyc));
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      check({tag, "_rd"}, {24'h0, rd_data}, 32'h0);
      check({tag, "_rd_sat"}, {24'h0, rd_data_s}, 32'h0);
    end
  endtask

  // Pulse rd_snap at the next falling edge, read all bytes, compare with model.
  task automatic do_snap(input string tag, input bit exp_busy);
    logic [7:0] b [8];
    logic [7:0] bs [8];
    @(negedge clk);
    rd_snap = 1'b1;
    @(negedge clk);
    rd_snap = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      b[i]  = rd_data;
      bs[i] = rd_data_s;
    end
    check({tag, "_res"}, {b[3], b[2], b[1], b[0]}, 32'(m_res));
    check({tag, "_st"}, {24'h0, b[4]}, {28'h0, exp_busy, 1'b0, m_valid, 1'b1});
    check({tag, "_res_sat"}, {bs[3], bs[2], bs[1], bs[0]}, sat4(m_res));
    check({tag, "_st_sat"}, {24'h0, bs[4]}, {28'h0, exp_busy, (m_res > 15), m_valid, 1'b1});
    check({tag, "_pad"}, {8'h0, b[7], b[6], b[5]}, 32'h0);
    m_valid = 1'b0;
  endtask

  initial begin
    int m, m2, m3, m4, len, dn;
    sys_rst  = 1'b1;
    meas_en  = 1'b1;
    gate_sel = 2'd0;
    rd_snap  = 1'b0;
    rd_sel   = 3'd0;
    per      = 10;
    hi       = 5;
    sig_run  = 1'b1;

    // Reset with measurement requested and input toggling.
    repeat (6) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check_zero("rst");

    // LATCH is the 102nd cycle after release, seen Unit+1 edges later.
    @(negedge clk);
    sys_rst = 1'b0;
    m = cyc + 1;
    wait_done("first_done", m + Unit);
    check("sat_done_lockstep", 32'(done_s), 32'h1);
    m_res   = count_rises(m, m + Unit - 1);
    m_valid = 1'b1;
    @(negedge clk);
    meas_en = 1'b0;
    do_snap("basic", 1'b0);
    do_snap("reread", 1'b0);

    // 100-unit gate; gate_sel change mid-gate applies only to the next gate.
    per = 4;
    hi  = $urandom_range(1, 3);
    @(negedge clk);
    gate_sel = 2'd2;
    meas_en  = 1'b1;
    m2 = cyc + 1;
    repeat (3000) @(negedge clk);
    gate_sel = 2'd0;
    wait_done("gate100_done", m2 + 100 * Unit);
    m_res   = count_rises(m2, m2 + 100 * Unit - 1);
    m_valid = 1'b1;
    @(negedge clk);
    do_snap("gate100", 1'b1);

    // Snap in the LATCH cycle: shadow holds the old result, live valid ends set.
    m3 = m2 + 100 * Unit + 1;
    wait_done("gate1_done", m3 + Unit);
    do_snap("collide", 1'b0);
    m_res   = count_rises(m3, m3 + Unit - 1);
    m_valid = 1'b1;
    do_snap("after_collide", 1'b1);

    // Abort at cycle 50 of the next gate.
    m4 = m3 + Unit + 1;
    while (cyc < m4 + 49) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'h1);
    meas_en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy_after", 32'(busy), 32'h0);
    dn = 0;
    repeat (150) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'h0);
    do_snap("abort", 1'b0);

    // Randomized waveforms and gate lengths.
    for (int t = 0; t < 3; t++) begin
      per      = $urandom_range(2, 12);
      hi       = $urandom_range(1, per - 1);
      gate_sel = 2'($urandom_range(0, 1));
      len      = (gate_sel == 2'd1) ? 10 * Unit : Unit;
      @(negedge clk);
      meas_en = 1'b1;
      m = cyc + 1;
      wait_done("rand_done", m + len);
      m_res   = count_rises(m, m + len - 1);
      m_valid = 1'b1;
      @(negedge clk);
      meas_en = 1'b0;
      do_snap("rand", 1'b0);
    end

    // Reset in the middle of a gate.
    per = 6;
    hi  = 3;
    @(negedge clk);
    gate_sel = 2'd1;
    meas_en  = 1'b1;
    repeat (30) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    m = cyc + 1;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check_zero("midrst");
    m_res   = 0;
    m_valid = 1'b0;
    wait_done("midrst_done_time", m + 10 * Unit);
    m_res   = count_rises(m, m + 10 * Unit - 1);
    m_valid = 1'b1;
    @(negedge clk);
    meas_en = 1'b0;
    do_snap("midrst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Gated frequency counter.
- Counts rising edges of an external signal over a programmable gate window derived from sys_clk_25m.
- Latches each result and presents it byte-wise to the register interface for SPI readout.
- Sits alongside the SPI register path in the frequency sample-and-control top, as the producer of measurement data consumed by reg_interface.

Parameters:
- GATE_UNIT, 250000, sys_clk_25m cycles per gate unit (10 ms at 25 MHz).
- CNT_W, 32, edge counter / result width in bits (fixed at 32 for 4-byte readout).

Ports:
- sys_clk_25m  in  1  system clock, 25 MHz.
- sys_rst  in  1  synchronous, active-high reset.
- sig_in  in  1  asynchronous signal under measurement.
- meas_en  in  1  level; 1 = continuous back-to-back measurement.
- gate_sel  in  2  gate length: 0=1, 1=10, 2=100, 3=1000 GATE_UNITs.
- rd_snap  in  1  one-cycle pulse; copies result and status into the read shadow.
- rd_sel  in  3  read byte select: 0..3 = shadow result bytes LSB..MSB; 4 = status; 5..7 = 0x00.
- rd_data  out  8  combinational mux of the read shadow by rd_sel.
- meas_busy  out  1  gate currently open.
- meas_done  out  1  one-cycle pulse when a new result is latched.

Behaviour:
- Clock and reset:
  - Single clock, sys_clk_25m.
  - Reset is synchronous, active-high on sys_rst.
  - Under reset: all counters, result, shadow, flags = 0; state = IDLE; meas_busy=0; meas_done=0; rd_data=0x00.
- Input conditioning:
  - sig_in passes through a 2-FF synchroniser, then a third register for edge detect.
  - edge = sync & ~prev.
  - Latency from a sig_in rising edge to the count increment is 3 cycles.
- Gate timing:
  - unit_cnt counts 0..GATE_UNIT-1.
  - dec_cnt counts completed units up to the gate limit: 1/10/100/1000.
  - gate_sel is sampled only at gate start; changes mid-gate are ignored until the next gate.
- State machine:
  - IDLE: meas_busy=0. If meas_en=1, next state is GATE; clear unit_cnt, dec_cnt and edge_cnt; sample gate_sel.
  - GATE: meas_busy=1. Count edges. When the last unit's last cycle completes, next state is LATCH. If meas_en=0, abort to IDLE: result and flags unchanged, no meas_done.
  - LATCH: one cycle.
    - result <= edge_cnt; ovf <= edge_ovf; valid <= 1; meas_done=1.
    - Next state is GATE (counters cleared, gate_sel resampled) if meas_en=1, else IDLE.
- Gate window: exactly N*GATE_UNIT cycles in GATE. Edges detected in the LATCH cycle are not counted; the dead time is 1 cycle.
- Edge counter saturation: the edge counter saturates at 2^CNT_W-1. Further edges set edge_ovf and do not wrap.
- Status byte (rd_sel=4): {4'b0, busy, ovf, valid, 1'b1}.
  - Bit0 is a constant-1 presence flag.
  - The status byte is captured at rd_snap.
- Snapshot:
  - rd_snap copies result, ovf, valid and meas_busy into the shadow.
  - rd_snap then clears the live valid flag (read-and-clear).
  - rd_data reflects only the shadow. The 4 bytes are therefore coherent regardless of later measurements.
- Simultaneous rd_snap and LATCH:
  - The shadow receives the previous result and flags.
  - The live valid ends at 1 (set wins over clear).
- Reset mid-gate: everything returns to reset values on the next edge; no meas_done.
- No handshake back-pressure: results overwrite unread results; valid simply stays 1.

Test Plan:
- Sim uses GATE_UNIT=100.
- Reset behaviour: assert sys_rst with meas_en=1 and sig_in toggling -> rd_data=0x00 for all rd_sel, meas_busy=0, meas_done=0; first meas_done exactly 1+100+1 cycles after release (IDLE, gate, LATCH).
- Basic count: sig_in period 10 cycles, gate_sel=0, rd_snap after meas_done -> result 10 (±1 for phase), status 0x03; second rd_snap without a new measurement -> status 0x01 (valid cleared).
- Gate select: sig_in period 4 cycles, gate_sel=2 -> result 2500±1; change gate_sel to 0 mid-gate -> current result still 2500±1, next result 25±1.
- Abort: drop meas_en at cycle 50 of the gate -> meas_busy falls next cycle, no meas_done, shadow still holds the prior result.
- Collision: rd_snap in the same cycle as meas_done -> shadow holds the old result; an immediate second rd_snap shows the new result with status valid=1.
- Saturation: force edge_cnt to 0xFFFFFFFE, apply 3 edges -> result 0xFFFFFFFF, status 0x07 (ovf set).
